// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ready bus with wait states, and feeds IF/ID.
// States: S_IDLE | dead cycle after reset ; S_REQ | request on bus ; S_HOLD | fetched word parked while stalled
module instruction_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_result_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_result_q, pc_result_d;
  logic        valid_q, valid_d;
  logic        drop_q, drop_d;

  logic [31:0] target;
  logic [31:0] next_seq;

  assign target   = {branch_target_i[31:2], 2'b00};
  assign next_seq = req_addr_q + PC_INC;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RESET;
      req_addr_q   <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      instr_q      <= '0;
      pc_result_q  <= '0;
      valid_q      <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      pc_result_q  <= pc_result_d;
      valid_q      <= valid_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_d      = instr_q;
    pc_result_d  = pc_result_q;
    valid_d      = valid_q;
    drop_d       = drop_q;

    if (branch_taken_i) begin
      pc_d    = target;
      valid_d = 1'b0;
      case (state_q)
        // An in-flight request cannot be withdrawn; mark its response for discard instead.
        S_REQ: begin
          if (imem_ready_i) begin
            req_addr_d = target;
            drop_d     = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: begin
          req_addr_d = target;
          state_d    = S_REQ;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          req_addr_d = pc_q;
          state_d    = S_REQ;
          if (!stall_i) valid_d = 1'b0;
        end
        S_REQ: begin
          if (!imem_ready_i) begin
            if (!stall_i) valid_d = 1'b0;
          end else if (drop_q) begin
            drop_d     = 1'b0;
            req_addr_d = pc_q;
            if (!stall_i) valid_d = 1'b0;
          end else if (!stall_i) begin
            instr_d     = imem_data_i;
            pc_result_d = next_seq;
            valid_d     = 1'b1;
            pc_d        = next_seq;
            req_addr_d  = next_seq;
          end else begin
            hold_instr_d = imem_data_i;
            hold_pc_d    = next_seq;
            pc_d         = next_seq;
            state_d      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            instr_d     = hold_instr_q;
            pc_result_d = hold_pc_q;
            valid_d     = 1'b1;
            req_addr_d  = pc_q;
            state_d     = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign imem_req_o    = (state_q == S_REQ);
  assign imem_addr_o   = req_addr_q;
  assign instruction_o = instr_q;
  assign pc_result_o   = pc_result_q;
  assign valid_o       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios, then randomized traffic checked
// against a program-order model (sequential addresses, redirected by each branch).
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] pcres;
  logic        valid;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit #(.PC_RESET(32'h0000_0000), .PC_INC(32'd4)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .stall_i         (stall),
    .branch_taken_i  (branch),
    .branch_target_i (target),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ready_i    (imem_ready),
    .imem_data_i     (imem_data),
    .instruction_o   (instr),
    .pc_result_o     (pcres),
    .valid_o         (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Instruction memory: word is a fixed function of the address; garbage when not ready.
  always_comb imem_data = imem_ready ? memword(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard state for the random phase
  bit          mon_en = 1'b0;
  bit          wait_prev = 1'b0;
  logic [31:0] wait_addr = '0;
  logic [31:0] next_exp = '0;
  logic [31:0] redir_q[$];
  int          consumed = 0;
  int          starve = 0;

  // Samples between input update (negedge+1) and the next posedge, so outputs and the
  // inputs that will act on them are seen together.
  always @(negedge clk) begin
    logic [31:0] t;
    #2;
    if (mon_en && rst_n) begin
      if (wait_prev) begin
        chk("rand_req_held", {31'd0, imem_req}, 32'd1);
        chk("rand_addr_stable", imem_addr, wait_addr);
      end
      wait_prev = imem_req && !imem_ready;
      wait_addr = imem_addr;
      if (valid && !stall) begin
        chk("rand_instr", instr, memword(next_exp));
        chk("rand_pcres", pcres, next_exp + 32'd4);
        next_exp = next_exp + 32'd4;
        consumed++;
        starve = 0;
      end else begin
        starve++;
        if (starve > 400) begin
          chk("rand_liveness", 32'(starve), 32'd0);
          starve = 0;
        end
      end
      if (branch) begin
        if (redir_q.size() == 0) begin
          chk("rand_redir_queue", 32'd0, 32'd1);
        end else begin
          t = redir_q.pop_front();
          next_exp = {t[31:2], 2'b00};
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] t;
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; target = '0; imem_ready = 1'b1;
    tick();
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pcres", pcres, 32'd0);
    chk("rst_addr",  imem_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("dead_cycle_req", {31'd0, imem_req}, 32'd0);

    // Sequential fetch, memory always ready
    tick();
    chk("t1_first_addr", imem_addr, 32'd0);
    chk("t1_first_req", {31'd0, imem_req}, 32'd1);
    chk("t1_first_bubble", {31'd0, valid}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_addr",  imem_addr, 32'(4 * i));
      chk("t1_pcres", pcres, 32'(4 * i));
      chk("t1_valid", {31'd0, valid}, 32'd1);
      chk("t1_instr", instr, memword(32'(4 * (i - 1))));
    end

    // Wait states at 0x10
    tick();
    chk("t2_pre_addr", imem_addr, 32'h10);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_addr_stable", imem_addr, 32'h10);
      chk("t2_wait_bubble", {31'd0, valid}, 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    chk("t2_instr", instr, memword(32'h10));
    chk("t2_pcres", pcres, 32'h14);
    chk("t2_valid", {31'd0, valid}, 32'd1);
    imem_ready = 1'b0;
    tick();
    chk("t2_one_pulse", {31'd0, valid}, 32'd0);

    // Stall while the word for 0x20 completes
    imem_ready = 1'b1;
    repeat (3) tick();
    chk("t3_pre_pcres", pcres, 32'h20);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_hold_req",   {31'd0, imem_req}, 32'd0);
      chk("t3_hold_pcres", pcres, 32'h20);
      chk("t3_hold_instr", instr, memword(32'h1C));
      chk("t3_hold_valid", {31'd0, valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("t3_instr", instr, memword(32'h20));
    chk("t3_pcres", pcres, 32'h24);
    chk("t3_next_addr", imem_addr, 32'h24);

    // Branch during an outstanding request to 0x30
    repeat (3) tick();
    chk("t4_pre_addr", imem_addr, 32'h30);
    imem_ready = 1'b0;
    tick();
    branch = 1'b1; target = 32'h103;
    tick();
    chk("t4_addr_kept", imem_addr, 32'h30);
    chk("t4_flush", {31'd0, valid}, 32'd0);
    branch = 1'b0; imem_ready = 1'b1;
    tick();
    chk("t4_discard", {31'd0, valid}, 32'd0);
    chk("t4_target_addr", imem_addr, 32'h100);
    tick();
    chk("t4_pcres", pcres, 32'h104);
    chk("t4_instr", instr, memword(32'h100));

    // Branch while stalled in HOLD
    stall = 1'b1;
    tick();
    chk("t5_in_hold", {31'd0, imem_req}, 32'd0);
    branch = 1'b1; target = 32'h200;
    tick();
    chk("t5_flush", {31'd0, valid}, 32'd0);
    chk("t5_addr", imem_addr, 32'h200);
    branch = 1'b0; stall = 1'b0;
    tick();
    chk("t5_pcres", pcres, 32'h204);
    chk("t5_instr", instr, memword(32'h200));

    // Wrap-around, then async reset mid-request
    branch = 1'b1; target = 32'hFFFF_FFF8;
    tick();
    chk("t6_flush", {31'd0, valid}, 32'd0);
    branch = 1'b0;
    tick();
    chk("t6_pcres_fffc", pcres, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap_pcres", pcres, 32'h0);
    chk("t6_wrap_instr", instr, memword(32'hFFFF_FFFC));
    chk("t6_wrap_addr",  imem_addr, 32'h0);
    branch = 1'b1; target = 32'hFFFF_FFFE;
    tick();
    chk("t6_target_mask", imem_addr, 32'hFFFF_FFFC);
    branch = 1'b0; imem_ready = 1'b0;
    tick();
    chk("t6_req_pending", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0; imem_ready = 1'b1;
    #1;
    chk("t6_async_req",   {31'd0, imem_req}, 32'd0);
    chk("t6_async_valid", {31'd0, valid}, 32'd0);
    chk("t6_async_pcres", pcres, 32'd0);
    chk("t6_async_instr", instr, 32'd0);
    chk("t6_async_addr",  imem_addr, 32'd0);
    repeat (2) tick();
    chk("t6_ignored_rsp", {31'd0, valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("t6_restart_addr", imem_addr, 32'h0);
    tick();
    chk("t6_restart_pcres", pcres, 32'h4);

    // Randomized traffic
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; imem_ready = 1'b0;
    tick();
    next_exp = 32'h0;
    redir_q.delete();
    mon_en = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (3000) begin
      @(negedge clk); #1;
      imem_ready = ($urandom_range(0, 99) < 60);
      stall      = ($urandom_range(0, 99) < 25);
      branch     = ($urandom_range(0, 99) < 6);
      t = $urandom;
      if (branch) begin
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | (t & 32'h1F);
        redir_q.push_back(t);
      end
      target = t;
    end
    @(negedge clk); #1;
    branch = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    repeat (5) @(posedge clk);
    mon_en = 1'b0;
    chk("rand_progress", {31'd0, (consumed > 100)}, 32'd1);
    chk("rand_redir_drained", 32'(redir_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
